insn_fetch_unit: RTL and testbench
==================================

// Module: insn_fetch_unit
// PURPOSE
//  - Upstream fetch stage for the AArch64-subset core. Assembles 32-bit instructions from the
//    byte-wide single-read-port memory: four byte reads, little-endian.
//  - Buffers fetched words in a small queue and presents {ins, ins_pc} to decode/execute over a
//    valid/ready handshake.
//  - Accepts a redirect (taken B, restart) that flushes the queue and restarts fetch at a new PC.
// PARAMETERS
//  ADDR_W    64  width of PC and byte address
//  RESET_PC  0   fetch PC loaded on reset
//  QDEPTH    2   instruction queue entries (power of 2, >=1)
// PORTS
//  clk             in   1       clock; all state updates on posedge
//  reset           in   1       synchronous, active-high reset
//  raddr           out  ADDR_W  memory byte read address (combinational from state)
//  rdata           in   8       memory byte at raddr, valid in the same cycle
//  ins_valid       out  1       queue head holds an instruction
//  ins_ready       in   1       consumer takes head this cycle when ins_valid=1
//  ins             out  32      head instruction word; 0 when queue empty
//  ins_pc          out  ADDR_W  address of head instruction; 0 when queue empty
//  redirect_valid  in   1       restart fetch at redirect_pc; flushes queue
//  redirect_pc     in   ADDR_W  new fetch PC; used unmodified (no alignment check)
//  halt            in   1       stop starting new instructions
// BEHAVIOUR
//  - State: fetch_pc, byte index bidx (0..3), partial word buf[23:0], queue, count (0..QDEPTH).
//  - raddr = fetch_pc + bidx, mod 2^ADDR_W. Wrap is silent.
//  - Cycle with bidx=0..2 and no redirect: buf byte bidx <= rdata, bidx++.
//  - Cycle with bidx=3, no redirect, and space: space = (count<QDEPTH) || (ins_valid && ins_ready).
//      push {pc=fetch_pc, ins={rdata,buf[23:0]}}; fetch_pc += 4; bidx <= 0.
//  - bidx=3 with no space: hold. raddr stays fetch_pc+3; no push. Rereading is harmless.
//  - halt=1 with bidx=0: hold at bidx=0 and do not capture. A word already in progress completes.
//  - Pop: ins_valid && ins_ready removes the head. Push and pop may occur in the same cycle;
//    count is unchanged.
//  - Redirect has highest priority. On the next edge: queue emptied, count=0,
//    fetch_pc <= redirect_pc, bidx <= 0, buf <= 0.
//    Any same-cycle push is discarded. Any same-cycle pop is a don't-care (queue flushed).
//  - Latency: first ins_valid 4 edges after reset/redirect. Throughput 1 insn per 4 cycles.
//  - Reset (overrides everything, including mid-word): fetch_pc=RESET_PC, bidx=0, buf=0,
//    count=0, ins_valid=0, ins=0, ins_pc=0, raddr=RESET_PC.
//  - ins/ins_pc/ins_valid are registered queue-head outputs, not a combinational path from rdata.
// STRUCTURE
//  - Shared package (core_pkg): INS_BYTES=4, typedef ins_t (32b), typedef addr_t (ADDR_W),
//    typedef fetch_entry_t {addr_t pc; ins_t ins;}.
//  - One sub-module: fetch_queue. Synchronous FIFO of fetch_entry_t, depth QDEPTH, push/pop/flush,
//    count output, simultaneous push+pop when full allowed.
//  - Top level holds only the byte-assembly counter and the redirect/halt control.
// TESTING
//  1. Reset; mem[0..3]=21 04 00 91, ins_ready=1.
//     -> raddr 0,1,2,3 on cycles 0-3; ins_valid=1 after edge 4; ins=32'h91000421, ins_pc=0.
//  2. ins_ready=0, sequential code at 0x0.
//     -> pc 0x0 and 0x4 queued by edge 8; fetch stalls with raddr=0xB held.
//     -> Raise ready: ins_pc 0x0, 0x4, 0x8 delivered in order, none lost or duplicated.
//  3. redirect_valid for 1 cycle at cycle 6, redirect_pc=0x100.
//     -> next cycle ins_valid=0, raddr=0x100; first valid ins_pc=0x100 4 edges later.
//     -> pc 0x4 is never delivered.
//  4. Redirect asserted on the bidx=3 cycle of pc 0x4. -> word for 0x4 is not pushed;
//     next delivered ins_pc = redirect_pc.
//  5. redirect_pc=64'hFFFF_FFFF_FFFF_FFFE. -> raddr ...FE, ...FF, 0x0, 0x1;
//     ins_pc=...FE; next fetch pc=0x2.
//  6. Assert reset at bidx=2 with one queued entry. -> next cycle ins_valid=0, ins=0,
//     raddr=RESET_PC; refetch from RESET_PC yields identical first instruction.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the fetch path: instruction word, byte address and queue entry.
package core_pkg;

    localparam int INS_BYTES = 4;
    // Widest address the queue entry can carry; the fetch unit's ADDR_W must not exceed it.
    localparam int ADDR_BITS = 64;

    typedef logic [31:0]          ins_t;
    typedef logic [ADDR_BITS-1:0] addr_t;

    typedef struct packed {
        addr_t pc;
        ins_t  ins;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, ins} entries with flush; push and pop may coincide when full.
module fetch_queue
    import core_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wdata,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= wdata;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/insn_fetch_unit.sv
// Fetch stage: assembles little-endian 32-bit words from a byte-wide memory and queues them.
module insn_fetch_unit
    import core_pkg::*;
#(
    parameter int               ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] raddr,
    input  logic [7:0]        rdata,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [31:0]       ins,
    output logic [ADDR_W-1:0] ins_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt
);

    localparam int CNT_W = $clog2(QDEPTH+1);

    logic [ADDR_W-1:0] fetch_pc;
    logic [1:0]        bidx;
    logic [23:0]       part_buf;
    logic [CNT_W-1:0]  count;
    fetch_entry_t      head;
    fetch_entry_t      entry;
    logic              space;
    logic              push;
    logic              pop;
    logic              halt_hold;

    assign raddr     = fetch_pc + ADDR_W'(bidx);
    assign ins_valid = (count != '0);
    assign ins       = ins_valid ? head.ins : '0;
    assign ins_pc    = ins_valid ? head.pc[ADDR_W-1:0] : '0;

    // A same-cycle pop frees a slot, so a full queue can still accept the last byte.
    assign space     = (int'(count) < QDEPTH) || (ins_valid && ins_ready);
    assign push      = (bidx == 2'd3) && space && !redirect_valid;
    assign pop       = ins_valid && ins_ready && !redirect_valid;
    assign halt_hold = halt && (bidx == 2'd0);

    assign entry.pc  = addr_t'(fetch_pc);
    assign entry.ins = {rdata, part_buf};

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            bidx     <= 2'd0;
            part_buf <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            bidx     <= 2'd0;
            part_buf <= '0;
        end else if (bidx != 2'd3) begin
            if (!halt_hold) begin
                case (bidx)
                    2'd0:    part_buf[7:0]   <= rdata;
                    2'd1:    part_buf[15:8]  <= rdata;
                    default: part_buf[23:16] <= rdata;
                endcase
                bidx <= bidx + 2'd1;
            end
        end else if (space) begin
            fetch_pc <= fetch_pc + ADDR_W'(INS_BYTES);
            bidx     <= 2'd0;
        end
    end

    fetch_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdata (entry),
        .head  (head),
        .count (count)
    );

endmodule

// File: tb/tb_insn_fetch_unit.sv
// Bench for insn_fetch_unit: directed scenarios plus randomized traffic against an in-order stream model.
module tb_insn_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] raddr;
    logic [7:0]  rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins;
    logic [63:0] ins_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;

    int n_vec = 0;
    int n_err = 0;
    int n_deliv = 0;

    logic [7:0]  mem_lo [0:511];
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    insn_fetch_unit #(.ADDR_W(64), .RESET_PC(64'h0), .QDEPTH(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .raddr          (raddr),
        .rdata          (rdata),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins            (ins),
        .ins_pc         (ins_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        if (a < 64'd512) return mem_lo[a[8:0]];
        return a[7:0] ^ a[15:8] ^ a[63:56] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] word_at(input logic [63:0] pc);
        return {mem_byte(pc + 64'd3), mem_byte(pc + 64'd2), mem_byte(pc + 64'd1), mem_byte(pc)};
    endfunction

    always_comb rdata = mem_byte(raddr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Stream model: the consumer must see consecutive pcs from the last reset/redirect target.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_q.push_back(64'h0);
        end else if (redirect_valid) begin
            exp_q.delete();
            exp_q.push_back(redirect_pc);
        end else begin
            if (ins_valid && ins_ready) begin
                logic [63:0] e;
                if (exp_q.size() == 0) begin
                    check("deliv_model_empty", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("deliv_pc", ins_pc, e);
                    check("deliv_ins", {32'h0, ins}, {32'h0, word_at(e)});
                    exp_q.push_back(e + 64'd4);
                    n_deliv++;
                end
            end
            if (!ins_valid) begin
                check("empty_ins", {32'h0, ins}, 64'h0);
                check("empty_pc", ins_pc, 64'h0);
            end
        end
    end

    initial begin
        reset = 1'b1; ins_ready = 1'b1; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        for (int i = 0; i < 512; i++) mem_lo[i] = 8'($urandom);
        mem_lo[0] = 8'h21; mem_lo[1] = 8'h04; mem_lo[2] = 8'h00; mem_lo[3] = 8'h91;

        // Reset state and first-word latency
        do_reset();
        check("rst_valid", {63'h0, ins_valid}, 64'h0);
        check("rst_raddr", raddr, 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("t1_raddr", raddr, 64'(i));
            step();
        end
        check("t1_valid", {63'h0, ins_valid}, 64'h1);
        check("t1_ins", {32'h0, ins}, 64'h91000421);
        check("t1_pc", ins_pc, 64'h0);

        // Backpressure: queue fills, fetch stalls on last byte of pc 0x8
        ins_ready = 1'b0;
        repeat (4) step();
        check("t2_head", ins_pc, 64'h0);
        repeat (3) step();
        check("t2_stall", raddr, 64'hB);
        repeat (5) step();
        check("t2_hold", raddr, 64'hB);
        check("t2_head2", ins_pc, 64'h0);
        ins_ready = 1'b1;
        check("t2_d0", ins_pc, 64'h0);
        step();
        check("t2_d1", ins_pc, 64'h4);
        step();
        check("t2_d2", ins_pc, 64'h8);

        // Redirect mid-word at cycle 6
        do_reset();
        repeat (6) step();
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        step();
        redirect_valid = 1'b0;
        check("t3_valid", {63'h0, ins_valid}, 64'h0);
        check("t3_raddr", raddr, 64'h100);
        repeat (4) step();
        check("t3_lat", {63'h0, ins_valid}, 64'h1);
        check("t3_pc", ins_pc, 64'h100);

        // Redirect on the final byte of pc 0x4 with pc 0x0 still queued
        do_reset();
        ins_ready = 1'b0;
        repeat (7) step();
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        step();
        redirect_valid = 1'b0;
        check("t4_valid", {63'h0, ins_valid}, 64'h0);
        repeat (4) step();
        check("t4_pc", ins_pc, 64'h40);
        ins_ready = 1'b1;
        step();

        // Address wrap
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check("t5_a0", raddr, 64'hFFFF_FFFF_FFFF_FFFE);
        step();
        check("t5_a1", raddr, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        check("t5_a2", raddr, 64'h0);
        step();
        check("t5_a3", raddr, 64'h1);
        step();
        check("t5_pc", ins_pc, 64'hFFFF_FFFF_FFFF_FFFE);
        check("t5_next", raddr, 64'h2);

        // Halt holds at a word boundary
        do_reset();
        halt = 1'b1;
        repeat (3) step();
        check("halt_raddr", raddr, 64'h0);
        check("halt_valid", {63'h0, ins_valid}, 64'h0);
        halt = 1'b0;
        repeat (4) step();
        check("halt_resume", ins_pc, 64'h0);

        // Reset mid-word with an entry queued
        do_reset();
        ins_ready = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        check("t6_valid", {63'h0, ins_valid}, 64'h0);
        check("t6_ins", {32'h0, ins}, 64'h0);
        check("t6_raddr", raddr, 64'h0);
        reset = 1'b0;
        repeat (4) step();
        check("t6_ins2", {32'h0, ins}, 64'h91000421);
        check("t6_pc2", ins_pc, 64'h0);
        ins_ready = 1'b1;

        // Randomized traffic
        do_reset();
        n_deliv = 0;
        for (int c = 0; c < 3000; c++) begin
            ins_ready = ($urandom_range(0, 3) != 0);
            halt = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) begin
                redirect_valid = 1'b1;
                if ($urandom_range(0, 1) == 0) redirect_pc = 64'($urandom_range(0, 500));
                else redirect_pc = {$urandom, $urandom};
            end else begin
                redirect_valid = 1'b0;
            end
            step();
        end
        redirect_valid = 1'b0; halt = 1'b0; ins_ready = 1'b1;
        repeat (10) step();
        check("rand_progress", {63'h0, (n_deliv > 100)}, 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
